dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port DMEM (16-bit x 1024, synchronous read, 1-cycle latency) between two packet requesters, e.g. two MA-stage lanes.
- Arbitrates round-robin and drives the DMEM port.
- Captures the granted 40-bit packet and merges the load result into bits [15:0] when a load is performed.
- Presents the result on a single Send/Ack output channel with backpressure.
- Synchronous design, intended to replace per-lane private DMEM instances.

Parameters:
- PKT_W, 40, packet width (equal to `MA_PACKET_SIZE`).
- DATA_W, 16, DMEM word width (`DMEM_WIDTH`).
- ADDR_W, 10, DMEM address width (log2 `DMEM_DEPTH`); the address is taken from `PACKET_IN[ADDR_W-1:0]`.

Ports:
- CP  in  1  clock, rising edge
- MR_N  in  1  master reset, asynchronous, active-low
- Send_in0 / Send_in1  in  1  request valid, held high until acknowledged
- Ack_out0 / Ack_out1  out  1  one-cycle grant/accept pulse (combinational)
- LOAD_FLG0 / LOAD_FLG1  in  1  request is a load; merge DMEM data into the packet
- WRITE_EN0 / WRITE_EN1  in  1  request is a store
- WRITE_DATA0 / WRITE_DATA1  in  DATA_W  store data
- PACKET_IN0 / PACKET_IN1  in  PKT_W  packet; bits [ADDR_W-1:0] are the address
- Send_out  out  1  output packet valid
- Ack_in  in  1  downstream accept
- PACKET_OUT  out  PKT_W  result packet
- dmem_wea  out  1  DMEM write enable
- dmem_addra  out  ADDR_W  DMEM address
- dmem_dina  out  DATA_W  DMEM write data
- dmem_douta  in  DATA_W  DMEM read data, valid one cycle after the address edge

Behaviour:
- Clock and reset: one clock, CP; MR_N is asynchronous and active-low.
- Reset (MR_N=0):
  - state=IDLE, rr_ptr=0, DL=0, PACKET_OUT=0, Send_out=0.
  - Ack_out0/1=0 and dmem_wea=0 (reset-qualified).
  - Reset mid-transaction drops the transaction; a DMEM write already clocked stays in memory.
- FSM states IDLE, MEM, OUT:
  - grant_ok = (state==IDLE) | (state==OUT & Ack_in).
  - On grant_ok with any Send_inN=1, select requester g:
    - If only one requester is active, g is that one.
    - If both are active, g = rr_ptr.
  - Grant cycle outputs (combinational): Ack_out[g]=1; dmem_addra=PACKET_IN_g[ADDR_W-1:0]; dmem_dina=WRITE_DATA_g; dmem_wea=WRITE_EN_g.
  - Grant edge actions:
    - DL <= {LOAD_FLG_g & ~WRITE_EN_g, PACKET_IN_g}; WRITE_EN overrides LOAD_FLG.
    - rr_ptr <= ~g.
    - state <= MEM.
  - No grant: dmem_wea=0, Ack_out=0, dmem_addra holds the last value (don't-care).
  - MEM: at the edge, PACKET_OUT <= DL[PKT_W] ? {DL[PKT_W-1:DATA_W], dmem_douta} : DL[PKT_W-1:0]; Send_out <= 1; state <= OUT.
  - OUT: Send_out=1 and PACKET_OUT is held stable while Ack_in=0.
  - OUT with Ack_in=1:
    - If a request is pending, grant in the same cycle, Send_out <= 0, state <= MEM.
    - Otherwise Send_out <= 0, state <= IDLE.
- Latency and throughput:
  - Grant edge t0 → Send_out high after edge t0+1.
  - Minimum 2 cycles per transaction under continuous Ack_in.
- Handshake rules:
  - Requesters keep Send_inN and all data stable until they sample Ack_outN=1.
  - Ack_outN is never asserted while state==MEM, or while state==OUT & Ack_in=0.
  - At most one Ack_out is high per cycle.
- Boundary conditions:
  - Simultaneous requests alternate strictly.
  - A lone requester is granted back-to-back regardless of rr_ptr.
  - Address wrap: only the low ADDR_W bits are used; upper packet bits pass through untouched.
  - Store followed by load to the same address is serialized by the FSM, so the load returns the new data.

Decomposition:
- macro.vh holds `MA_PACKET_SIZE`, `DMEM_WIDTH`, `DMEM_DEPTH` and new state encodings `ARB_IDLE`/`ARB_MEM`/`ARB_OUT` (2-bit).
- One sub-module, rr_arb2: inputs req[1:0], en, ptr; output one-hot gnt[1:0].
- The DMEM IP stays external and is connected through the dmem_* ports.

Test Plan:
- Reset: MR_N low mid-OUT → Send_out=0, PACKET_OUT=0, Ack_out0/1=0 immediately; after release, the first simultaneous request grants requester 0.
- Store then load:
  - Req0 store WRITE_DATA0=16'hBEEF, PACKET_IN0=40'hAA_0000_0005 → dmem_wea=1, addra=5; PACKET_OUT=40'hAA_0000_0005 (unmerged).
  - Then req1 load, PACKET_IN1=40'h12_3456_0005 → PACKET_OUT=40'h12_3456_BEEF.
- Both requesters held high for 6 transactions with Ack_in=1 → grants 0,1,0,1,0,1, Send_out rises on every second cycle.
- Backpressure: Ack_in=0 for 5 cycles in OUT with a request pending → PACKET_OUT stable, no Ack_out, no dmem_wea; Ack_in=1 → pending request is granted in that same cycle.
- LOAD_FLG=1 & WRITE_EN=1, packet 40'h01_0000_0003, data 16'h7777 → memory[3]=16'h7777, PACKET_OUT=40'h01_0000_0003.
- Address wrap: PACKET_IN=40'hFF_FFFF_FC01 load → dmem_addra=10'h001, PACKET_OUT[39:16]=24'hFFFFFF.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared sizes and FSM encodings for the DMEM arbiter
// Contents:
//   MA_PACKET_SIZE  width of an MA-stage packet
//   DMEM_WIDTH      DMEM word width
//   DMEM_DEPTH      DMEM word count
//   arb_state_t     arbiter FSM encoding (ARB_IDLE / ARB_MEM / ARB_OUT)
package dmem_arbiter_pkg;

  localparam int MA_PACKET_SIZE = 40;
  localparam int DMEM_WIDTH     = 16;
  localparam int DMEM_DEPTH     = 1024;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_MEM  = 2'd1,
    ARB_OUT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin grant selector
// Ports:
//   req[1:0]  request vector
//   en        grant window open
//   ptr       preferred requester when both request
//   gnt[1:0]  one-hot grant, all zero when en=0 or no request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      // A lone requester wins regardless of the pointer.
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one DMEM port between two packet requesters
// Ports:
//   CP, MR_N                       clock, async active-low reset
//   Send_inN / Ack_outN            request valid / one-cycle accept (N = 0,1)
//   LOAD_FLGN, WRITE_ENN           request is a load / store
//   WRITE_DATAN, PACKET_INN        store data / packet (low ADDR_W bits = address)
//   Send_out / Ack_in / PACKET_OUT result channel with backpressure
//   dmem_wea/addra/dina/douta      external synchronous DMEM port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int PKT_W  = MA_PACKET_SIZE,
  parameter int DATA_W = DMEM_WIDTH,
  parameter int ADDR_W = $clog2(DMEM_DEPTH)
) (
  input  logic              CP,
  input  logic              MR_N,
  input  logic              Send_in0,
  input  logic              Send_in1,
  output logic              Ack_out0,
  output logic              Ack_out1,
  input  logic              LOAD_FLG0,
  input  logic              LOAD_FLG1,
  input  logic              WRITE_EN0,
  input  logic              WRITE_EN1,
  input  logic [DATA_W-1:0] WRITE_DATA0,
  input  logic [DATA_W-1:0] WRITE_DATA1,
  input  logic [PKT_W-1:0]  PACKET_IN0,
  input  logic [PKT_W-1:0]  PACKET_IN1,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [PKT_W-1:0]  PACKET_OUT,
  output logic              dmem_wea,
  output logic [ADDR_W-1:0] dmem_addra,
  output logic [DATA_W-1:0] dmem_dina,
  input  logic [DATA_W-1:0] dmem_douta
);

  arb_state_t        state;
  logic              rr_ptr;
  logic [PKT_W:0]    dl;      // {merge-load flag, captured packet}
  logic [ADDR_W-1:0] addr_q;  // last granted address, held while idle

  logic              grant_ok;
  logic [1:0]        gnt;
  logic              granted;
  logic              g;
  logic [PKT_W-1:0]  sel_pkt;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_load;

  // A new grant is possible when idle, or when the held result leaves this cycle.
  assign grant_ok = (state == ARB_IDLE) | ((state == ARB_OUT) & Ack_in);

  rr_arb2 u_rr_arb2 (
    .req (({Send_in1, Send_in0})),
    .en  (grant_ok),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign granted   = |gnt;
  assign g         = gnt[1];
  assign sel_pkt   = g ? PACKET_IN1  : PACKET_IN0;
  assign sel_wdata = g ? WRITE_DATA1 : WRITE_DATA0;
  assign sel_we    = g ? WRITE_EN1   : WRITE_EN0;
  assign sel_load  = g ? LOAD_FLG1   : LOAD_FLG0;

  // Handshake and write strobe are forced low while reset is asserted.
  assign Ack_out0   = gnt[0] & MR_N;
  assign Ack_out1   = gnt[1] & MR_N;
  assign dmem_wea   = granted & sel_we & MR_N;
  assign dmem_addra = granted ? sel_pkt[ADDR_W-1:0] : addr_q;
  assign dmem_dina  = sel_wdata;

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      state      <= ARB_IDLE;
      rr_ptr     <= 1'b0;
      dl         <= '0;
      addr_q     <= '0;
      PACKET_OUT <= '0;
      Send_out   <= 1'b0;
    end else begin
      if (granted) begin
        // A store never merges read data, even if the load flag is also set.
        dl     <= {sel_load & ~sel_we, sel_pkt};
        rr_ptr <= ~g;
        addr_q <= sel_pkt[ADDR_W-1:0];
      end
      case (state)
        ARB_IDLE: begin
          if (granted) state <= ARB_MEM;
        end
        ARB_MEM: begin
          // Read data for the address clocked at the grant edge is valid now.
          PACKET_OUT <= dl[PKT_W] ? {dl[PKT_W-1:DATA_W], dmem_douta} : dl[PKT_W-1:0];
          Send_out   <= 1'b1;
          state      <= ARB_OUT;
        end
        ARB_OUT: begin
          if (Ack_in) begin
            Send_out <= 1'b0;
            state    <= granted ? ARB_MEM : ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
